kbd_decoder: RTL and testbench

KBD_DECODER -- requirements
Module: kbd_decoder

---
 rtl/kbd_pkg.sv | 25 ++
 rtl/kbd_ascii_rom.sv | 31 +++
 rtl/kbd_decoder.sv | 153 +++++++++++++++
 tb/tb_kbd_decoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants and state type for the PS/2 scan-code decoder.
// Contents: prefix/ignore byte constants, the prefix FSM state enum and a
// helper that flags bytes the decoder drops silently in S_IDLE.
package kbd_pkg;

  localparam logic [7:0] KBD_BREAK  = 8'hF0;
  localparam logic [7:0] KBD_EXT    = 8'hE0;
  localparam logic [7:0] KBD_BAT_OK = 8'hAA;
  localparam logic [7:0] KBD_ECHO   = 8'hEE;
  localparam logic [7:0] KBD_ACK    = 8'hFA;
  localparam logic [7:0] KBD_PAUSE  = 8'hE1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BREAK     = 2'd1,
    S_EXT       = 2'd2,
    S_EXT_BREAK = 2'd3
  } kbd_state_e;

  function automatic logic kbd_is_ignored(input logic [7:0] b);
    return (b == KBD_BAT_OK) || (b == KBD_ECHO) ||
           (b == KBD_ACK)    || (b == KBD_PAUSE);
  endfunction

endpackage

// File: rtl/kbd_ascii_rom.sv
// Scan-code set 2 to ASCII lookup (combinational).
// Ports: code  - 8-bit make code
//        ascii - ASCII value, 0 when the code has no mapping
module kbd_ascii_rom (
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;  8'h66: ascii = 8'h08;
      8'h0D: ascii = 8'h09;  8'h76: ascii = 8'h1B;
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/kbd_decoder.sv
// PS/2 keyboard scan-code decoder: pops bytes from the receiver FIFO,
// tracks F0/E0 prefixes and reports make/break events.
// Build option: KBD_REPEAT_FILTER_EN - drop typematic repeats of the held key.
// Ports: clk, resetn (async active-low)
//        ps2_data_in/ps2_ready/ps2_overflow - FIFO head, non-empty, overflow
//        nextdata_n   - active-low one-cycle pop strobe
//        key_code/key_ext/key_pressed/key_ascii/key_count - last make state
//        event_valid/event_break - one-cycle event pulse and its type
//        ovf_flag     - sticky FIFO overflow
//
// state       | meaning
// S_IDLE      | no prefix pending
// S_BREAK     | F0 seen, next byte is a release
// S_EXT       | E0 seen, next byte is an extended code
// S_EXT_BREAK | E0 F0 seen, next byte is an extended release
import kbd_pkg::*;

module kbd_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       ps2_data_in,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_pressed,
  output logic [7:0]       key_ascii,
  output logic [CNT_W-1:0] key_count,
  output logic             event_valid,
  output logic             event_break,
  output logic             ovf_flag
);

  kbd_state_e       r_state, w_state_nxt;
  logic             r_pop;
  logic [7:0]       r_byte;
  logic [7:0]       r_key_code;
  logic             r_key_ext;
  logic             r_pressed;
  logic [CNT_W-1:0] r_count;
  logic             r_ev_valid;
  logic             r_ev_break;
  logic             r_ovf;

  logic       w_make;
  logic       w_break;
  logic       w_ext;
  logic       w_match;
  logic       w_suppress;
  logic       w_make_ok;
  logic [7:0] w_rom_ascii;

  // The latched byte is consumed at the edge that ends the pop cycle, so
  // r_pop doubles as "byte valid for the FSM" and blocks ready sampling.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pop  <= 1'b0;
      r_byte <= 8'h00;
    end else if (!r_pop && ps2_ready) begin
      r_pop  <= 1'b1;
      r_byte <= ps2_data_in;
    end else begin
      r_pop  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_break     = 1'b0;
    if (r_pop) begin
      case (r_state)
        S_IDLE: begin
          if (r_byte == KBD_BREAK)          w_state_nxt = S_BREAK;
          else if (r_byte == KBD_EXT)       w_state_nxt = S_EXT;
          else if (!kbd_is_ignored(r_byte)) w_make = 1'b1;
        end
        S_EXT: begin
          if (r_byte == KBD_BREAK) begin
            w_state_nxt = S_EXT_BREAK;
          end else begin
            w_make      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          // A second prefix inside a break sequence is malformed: drop it.
          w_state_nxt = S_IDLE;
          w_break     = (r_byte != KBD_BREAK) && (r_byte != KBD_EXT);
        end
      endcase
    end
  end

  assign w_ext   = (r_state == S_EXT) || (r_state == S_EXT_BREAK);
  assign w_match = (r_byte == r_key_code) && (w_ext == r_key_ext);

`ifdef KBD_REPEAT_FILTER_EN
  assign w_suppress = r_pressed && w_match;
`else
  assign w_suppress = 1'b0;
`endif

  assign w_make_ok = w_make && !w_suppress;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_key_code <= 8'h00;
      r_key_ext  <= 1'b0;
      r_pressed  <= 1'b0;
      r_count    <= '0;
      r_ev_valid <= 1'b0;
      r_ev_break <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_ev_valid <= w_make_ok || w_break;
      r_ev_break <= w_break;
      if (ps2_overflow) r_ovf <= 1'b1;
      if (w_make_ok) begin
        r_key_code <= r_byte;
        r_key_ext  <= w_ext;
        r_pressed  <= 1'b1;
        r_count    <= r_count + 1'b1;
      end else if (w_break && w_match) begin
        r_pressed  <= 1'b0;
      end
    end
  end

  kbd_ascii_rom u_rom (
    .code  (r_key_code),
    .ascii (w_rom_ascii)
  );

  assign nextdata_n  = ~r_pop;
  assign key_code    = r_key_code;
  assign key_ext     = r_key_ext;
  assign key_pressed = r_pressed;
  assign key_ascii   = r_key_ext ? 8'h00 : w_rom_ascii;
  assign key_count   = r_count;
  assign event_valid = r_ev_valid;
  assign event_break = r_ev_break;
  assign ovf_flag    = r_ovf;

endmodule

// File: tb/tb_kbd_decoder.sv
module tb_kbd_decoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] ps2_data_in = 8'h00;
  logic       ps2_ready = 1'b0;
  logic       ps2_overflow = 1'b0;
  logic       nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_pressed;
  logic [7:0] key_ascii;
  logic [7:0] key_count;
  logic       event_valid;
  logic       event_break;
  logic       ovf_flag;

  int compared = 0;
  int mismatched = 0;
  int ev_cnt = 0;
  int last_break = 0;

  kbd_decoder #(.CNT_W(8)) dut (
    .clk(clk), .resetn(resetn), .ps2_data_in(ps2_data_in),
    .ps2_ready(ps2_ready), .ps2_overflow(ps2_overflow),
    .nextdata_n(nextdata_n), .key_code(key_code), .key_ext(key_ext),
    .key_pressed(key_pressed), .key_ascii(key_ascii), .key_count(key_count),
    .event_valid(event_valid), .event_break(event_break), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (event_valid) begin
      ev_cnt = ev_cnt + 1;
      last_break = int'(event_break);
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    ps2_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Present one byte at the FIFO head, wait for the pop, then let the event settle.
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    @(negedge clk);
    ps2_data_in = b;
    ps2_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (nextdata_n === 1'b0) begin
        got = 1;
        break;
      end
    end
    ps2_ready = 1'b0;
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL pop_timeout byte=%h: no nextdata_n pulse within 8 cycles", b);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    compared++;
    if ({nextdata_n, key_code, key_ext, key_pressed, key_count, event_valid, event_break, ovf_flag, key_ascii}
        !== {1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      mismatched++;
      $display("FAIL reset_state: ndn=%b code=%h ext=%b pr=%b cnt=%h ev=%b brk=%b ovf=%b asc=%h, want 1/00/0/0/00/0/0/0/00",
               nextdata_n, key_code, key_ext, key_pressed, key_count, event_valid, event_break, ovf_flag, key_ascii);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_make();
    @(negedge clk);
    ps2_data_in = 8'h1C;
    ps2_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (nextdata_n !== 1'b0 || event_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL make_pop_cycle: nextdata_n=%b event_valid=%b, want 0/0", nextdata_n, event_valid);
    end
    ps2_ready = 1'b0;
    @(negedge clk);
    compared++;
    if (nextdata_n !== 1'b1 || event_valid !== 1'b1 || event_break !== 1'b0) begin
      mismatched++;
      $display("FAIL make_event_cycle: nextdata_n=%b event_valid=%b event_break=%b, want 1/1/0",
               nextdata_n, event_valid, event_break);
    end
    compared++;
    if (key_code !== 8'h1C || key_ascii !== 8'h61 || key_count !== 8'd1 || key_pressed !== 1'b1 || key_ext !== 1'b0) begin
      mismatched++;
      $display("FAIL make_key_state: code=%h asc=%h cnt=%0d pr=%b ext=%b, want 1c/61/1/1/0",
               key_code, key_ascii, key_count, key_pressed, key_ext);
    end
    @(negedge clk);
    compared++;
    if (event_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL make_pulse_width: event_valid=%b, want 0", event_valid);
    end
  endtask

  task automatic test_break();
    int ev0;
    apply_reset();
    ev0 = ev_cnt;
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    compared++;
    if (ev_cnt - ev0 !== 2 || last_break !== 1) begin
      mismatched++;
      $display("FAIL break_events: events=%0d last_break=%0d, want 2/1", ev_cnt - ev0, last_break);
    end
    compared++;
    if (key_pressed !== 1'b0 || key_count !== 8'd1) begin
      mismatched++;
      $display("FAIL break_state: pressed=%b count=%0d, want 0/1", key_pressed, key_count);
    end
    send_byte(8'h32);
    send_byte(8'hF0);
    send_byte(8'h1C);
    compared++;
    if (key_pressed !== 1'b1 || last_break !== 1 || key_code !== 8'h32 || ev_cnt - ev0 !== 4) begin
      mismatched++;
      $display("FAIL break_nonmatch: pressed=%b last_break=%0d code=%h events=%0d, want 1/1/32/4",
               key_pressed, last_break, key_code, ev_cnt - ev0);
    end
    ev0 = ev_cnt;
    send_byte(8'hAA);
    send_byte(8'hFA);
    compared++;
    if (ev_cnt - ev0 !== 0 || key_count !== 8'd2) begin
      mismatched++;
      $display("FAIL ignore_codes: events=%0d count=%0d, want 0/2", ev_cnt - ev0, key_count);
    end
  endtask

  task automatic test_ext();
    int ev0;
    apply_reset();
    ev0 = ev_cnt;
    send_byte(8'hE0);
    compared++;
    if (ev_cnt - ev0 !== 0) begin
      mismatched++;
      $display("FAIL ext_prefix_no_event: events=%0d, want 0", ev_cnt - ev0);
    end
    send_byte(8'h75);
    compared++;
    if (key_ext !== 1'b1 || key_code !== 8'h75 || key_ascii !== 8'h00 || key_pressed !== 1'b1) begin
      mismatched++;
      $display("FAIL ext_make: ext=%b code=%h asc=%h pr=%b, want 1/75/00/1", key_ext, key_code, key_ascii, key_pressed);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    compared++;
    if (ev_cnt - ev0 !== 1 || key_pressed !== 1'b1) begin
      mismatched++;
      $display("FAIL ext_break_prefix: events=%0d pr=%b, want 1/1", ev_cnt - ev0, key_pressed);
    end
    send_byte(8'h75);
    compared++;
    if (ev_cnt - ev0 !== 2 || last_break !== 1 || key_pressed !== 1'b0 || key_count !== 8'd1) begin
      mismatched++;
      $display("FAIL ext_break: events=%0d last_break=%0d pr=%b cnt=%0d, want 2/1/0/1",
               ev_cnt - ev0, last_break, key_pressed, key_count);
    end
    // A plain (non-extended) break of the same code must not release the E0 key.
    send_byte(8'hE0);
    send_byte(8'h5A);
    send_byte(8'hF0);
    send_byte(8'h5A);
    compared++;
    if (key_pressed !== 1'b1 || key_ascii !== 8'h00 || key_ext !== 1'b1) begin
      mismatched++;
      $display("FAIL ext_vs_plain_break: pr=%b asc=%h ext=%b, want 1/00/1", key_pressed, key_ascii, key_ext);
    end
  endtask

  task automatic test_repeat();
    int ev0;
    int exp_cnt;
    apply_reset();
    ev0 = ev_cnt;
    for (int i = 0; i < 3; i++) send_byte(8'h1C);
`ifdef KBD_REPEAT_FILTER_EN
    exp_cnt = 1;
`else
    exp_cnt = 3;
`endif
    compared++;
    if (int'(key_count) !== exp_cnt || ev_cnt - ev0 !== exp_cnt) begin
      mismatched++;
      $display("FAIL repeat_count: count=%0d events=%0d, want %0d/%0d", key_count, ev_cnt - ev0, exp_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap_ovf();
    apply_reset();
    for (int i = 0; i < 256; i++) send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
    compared++;
    if (key_count !== 8'd0 || key_code !== 8'h32 || key_pressed !== 1'b1) begin
      mismatched++;
      $display("FAIL count_wrap: count=%0d code=%h pr=%b, want 0/32/1", key_count, key_code, key_pressed);
    end
    @(negedge clk);
    ps2_overflow = 1'b1;
    @(negedge clk);
    ps2_overflow = 1'b0;
    repeat (10) @(negedge clk);
    compared++;
    if (ovf_flag !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_sticky: ovf_flag=%b, want 1", ovf_flag);
    end
    apply_reset();
    compared++;
    if (ovf_flag !== 1'b0) begin
      mismatched++;
      $display("FAIL ovf_reset_clear: ovf_flag=%b, want 0", ovf_flag);
    end
  endtask

  task automatic test_reset_mid();
    int ev0;
    bit ndn_bad = 0;
    apply_reset();
    send_byte(8'hF0);
    @(negedge clk);
    resetn = 1'b0;
    ps2_data_in = 8'h1C;
    ps2_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (nextdata_n !== 1'b1) ndn_bad = 1;
    end
    compared++;
    if (ndn_bad) begin
      mismatched++;
      $display("FAIL reset_nextdata: nextdata_n went low during reset, want 1");
    end
    resetn = 1'b1;
    ps2_ready = 1'b0;
    ev0 = ev_cnt;
    send_byte(8'h1C);
    compared++;
    if (ev_cnt - ev0 !== 1 || last_break !== 0 || key_pressed !== 1'b1 || key_count !== 8'd1 || key_code !== 8'h1C) begin
      mismatched++;
      $display("FAIL reset_mid_prefix: events=%0d last_break=%0d pr=%b cnt=%0d code=%h, want 1/0/1/1/1c",
               ev_cnt - ev0, last_break, key_pressed, key_count, key_code);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext();
    test_repeat();
    test_wrap_ovf();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
